alu_cmd_sequencer: RTL and testbench

- Initiator side of the ALU command interface. Accepts operation requests (ALUOp, funct, operands) over a valid/ready handshake and decodes each to the 4-bit ALU control code.
- Drives the combinational ALU, registers its result and zero flag, and returns a response over a second valid/ready handshake.
- Sequences a two-pass compound op (BLE) through the same ALU.
- Sits between the decode stage and the ALU in the multi-cycle datapath.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - ALU control codes, ALUOp/funct encodings and sequencer state type
package alu_seq_pkg;

    localparam int CTRL_CODE_W = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_BLE   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct to ALU control code decoder
module alu_ctrl_decode
    import alu_seq_pkg::*;
(
    input  logic [1:0]             aluop,
    input  logic [5:0]             funct,
    output logic [CTRL_CODE_W-1:0] ctrl,
    output logic                   is_compound,
    output logic                   illegal
);

    always_comb begin
        ctrl        = ALU_ADD;
        is_compound = 1'b0;
        illegal     = 1'b0;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default: begin
                        ctrl    = ALU_AND;
                        illegal = 1'b1;
                    end
                endcase
            end
            // Compound branch starts with a subtract; the SLT pass is sequenced later
            ALUOP_BLE: begin
                ctrl        = ALU_SUB;
                is_compound = 1'b1;
            end
            default: ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - request/response sequencer driving a combinational ALU
// Optional op_count_o handshake counter when ALU_SEQ_STATS_EN is defined.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]       op_count_o,
`endif
    output logic              rsp_err_o
);

    seq_state_t             state;
    logic [CTRL_CODE_W-1:0] dec_ctrl;
    logic                   dec_compound;
    logic                   dec_illegal;
    logic                   is_ble;
    logic                   pass1_zero;

    alu_ctrl_decode u_decode (
        .aluop       (aluop_i),
        .funct       (funct_i),
        .ctrl        (dec_ctrl),
        .is_compound (dec_compound),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_err_o    <= 1'b0;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_ctrl_o   <= '0;
            is_ble       <= 1'b0;
            pass1_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        alu_src1_o  <= src1_i;
                        alu_src2_o  <= src2_i;
                        is_ble      <= dec_compound;
                        if (dec_illegal) begin
                            // Illegal funct never touches the ALU
                            rsp_valid_o  <= 1'b1;
                            rsp_err_o    <= 1'b1;
                            rsp_result_o <= '0;
                            rsp_zero_o   <= 1'b0;
                            state        <= ST_RESP;
                        end else begin
                            alu_ctrl_o <= CTRL_W'(dec_ctrl);
                            rsp_err_o  <= 1'b0;
                            state      <= ST_EXEC1;
                        end
                    end
                end
                ST_EXEC1: begin
                    if (is_ble) begin
                        pass1_zero <= alu_zero_i;
                        alu_ctrl_o <= CTRL_W'(ALU_SLT);
                        state      <= ST_EXEC2;
                    end else begin
                        rsp_result_o <= alu_result_i;
                        rsp_zero_o   <= (alu_ctrl_o == CTRL_W'(ALU_SUB)) && alu_zero_i;
                        rsp_valid_o  <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_EXEC2: begin
                    // Taken when src1 == src2 (pass 1) or src1 < src2 (pass 2), signed
                    rsp_result_o <= alu_result_i;
                    rsp_zero_o   <= pass1_zero | alu_result_i[0];
                    rsp_valid_o  <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_count_o <= '0;
        end else if (state == ST_RESP && rsp_valid_o && rsp_ready_i) begin
            op_count_o <= op_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count;
    int          exp_count;
`endif

    int checks;
    int failures;

    alu_cmd_sequencer #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .aluop_i      (aluop),
        .funct_i      (funct),
        .src1_i       (src1),
        .src2_i       (src2),
        .alu_src1_o   (alu_src1),
        .alu_src2_o   (alu_src2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
`ifdef ALU_SEQ_STATS_EN
        .op_count_o   (op_count),
`endif
        .rsp_err_o    (rsp_err)
    );

    // Reference combinational ALU
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: alu_result = alu_src1 + alu_src2;
            4'b0110: alu_result = alu_src1 - alu_src2;
            4'b0111: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] exp_ctrl, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_z, input logic exp_e);
        int lat;
        @(negedge clk);
        aluop = op; funct = fn; src1 = a; src2 = b;
        req_valid = 1'b1;
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        if (!exp_e) check({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, exp_ctrl});
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_z});
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
        if (rsp_ready) begin
            @(posedge clk); #1;
`ifdef ALU_SEQ_STATS_EN
            exp_count++;
            check({tag, "_count"}, {16'd0, op_count}, exp_count);
`endif
            check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
`ifdef ALU_SEQ_STATS_EN
        exp_count = 0;
`endif
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        aluop = 2'b00; funct = 6'h00; src1 = 32'd0; src2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_src1", alu_src1, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("radd",  2'b10, 6'h20, 32'd5,        32'd7,        4'b0010, 2, 32'd12,       1'b0, 1'b0);
        run_op("beq_eq",2'b01, 6'h00, 32'h1234,     32'h1234,     4'b0110, 2, 32'd0,        1'b1, 1'b0);
        run_op("beq_ne",2'b01, 6'h00, 32'h1234,     32'h1235,     4'b0110, 2, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("addwrap",2'b00,6'h00, 32'hFFFFFFFF, 32'd1,        4'b0010, 2, 32'd0,        1'b0, 1'b0);
        run_op("rsub",  2'b10, 6'h22, 32'd5,        32'd5,        4'b0110, 2, 32'd0,        1'b1, 1'b0);
        run_op("rand",  2'b10, 6'h24, 32'h0000F0F0, 32'h00000FF0, 4'b0000, 2, 32'h000000F0, 1'b0, 1'b0);
        run_op("ror",   2'b10, 6'h25, 32'h0000F0F0, 32'h00000FF0, 4'b0001, 2, 32'h0000FFF0, 1'b0, 1'b0);
        run_op("rslt",  2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,        4'b0111, 2, 32'd1,        1'b0, 1'b0);
        run_op("ble_lt",2'b11, 6'h00, 32'hFFFFFFFD, 32'd4,        4'b0110, 3, 32'd1,        1'b1, 1'b0);
        run_op("ble_eq",2'b11, 6'h00, 32'd9,        32'd9,        4'b0110, 3, 32'd0,        1'b1, 1'b0);
        run_op("ble_gt",2'b11, 6'h00, 32'd10,       32'd9,        4'b0110, 3, 32'd0,        1'b0, 1'b0);

        // Backpressure on an illegal-funct response
        rsp_ready = 1'b0;
        run_op("illegal", 2'b10, 6'h3F, 32'd3, 32'd4, 4'b0000, 1, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_err", {31'd0, rsp_err}, 32'd1);
            check("bp_result", rsp_result, 32'd0);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
`ifdef ALU_SEQ_STATS_EN
        exp_count++;
        check("bp_count", {16'd0, op_count}, exp_count);
`endif
        check("bp_released", {31'd0, rsp_valid}, 32'd0);
        check("bp_idle_ready", {31'd0, req_ready}, 32'd1);

        // Asynchronous reset while in EXEC1
        @(negedge clk);
        aluop = 2'b10; funct = 6'h20; src1 = 32'd5; src2 = 32'd7;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_ctrl", {28'd0, alu_ctrl}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("arst_src1", alu_src1, 32'd0);
        check("arst_src2", alu_src2, 32'd0);
        check("arst_result", rsp_result, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
`ifdef ALU_SEQ_STATS_EN
        check("post_rst_count", {16'd0, op_count}, 32'd0);
`endif
        run_op("post_rst_add", 2'b00, 6'h00, 32'd100, 32'd23, 4'b0010, 2, 32'd123, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
